// File: rtl/uart_tx.sv
// UART transmitter: serialises NB_DATA-bit words as start/data(LSB first)/stop frames
// timed by a shared 16x-oversampling baud tick.
module uart_tx #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_tx_done
);

  localparam int TICK_SPAN = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int TW        = $clog2(TICK_SPAN);
  localparam int BW        = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [TW-1:0] BIT_END  = TW'(15);
  localparam logic [TW-1:0] STOP_END = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NB_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_next;
  logic [TW-1:0]      tick_cnt, tick_next;
  logic [BW-1:0]      bit_cnt, bit_next;
  logic [NB_DATA-1:0] shreg, shreg_next;
  logic               tx_next, done_next;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      o_tx      <= 1'b1;
      o_tx_done <= 1'b0;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_next;
      bit_cnt   <= bit_next;
      shreg     <= shreg_next;
      o_tx      <= tx_next;
      o_tx_done <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    done_next  = 1'b0;
    tx_next    = 1'b1;

    case (state)
      IDLE: begin
        if (i_tx_start) begin
          shreg_next = i_data;
          tick_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (i_tick) begin
          if (tick_cnt == BIT_END) begin
            tick_next  = '0;
            bit_next   = '0;
            state_next = DATA;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (tick_cnt == BIT_END) begin
            tick_next  = '0;
            shreg_next = shreg >> 1;
            if (bit_cnt == LAST_BIT) begin
              state_next = STOP;
            end else begin
              bit_next = bit_cnt + 1'b1;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (tick_cnt == STOP_END) begin
            tick_next  = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is registered, so it follows the state being entered.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed and random frames checked against a tick-count model of
// the serial line, with two instances covering 1 and 2 stop bits.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       start16, start32;
  logic [7:0] data16, data32;
  logic       tx16, busy16, done16;
  logic       tx32, busy32, done32;

  int vectors = 0;
  int miscompares = 0;
  int gap = 4;

  uart_tx #(.NB_DATA(8), .SB_TICK(16)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_tick(tick), .i_tx_start(start16),
    .i_data(data16), .o_tx(tx16), .o_busy(busy16), .o_tx_done(done16)
  );

  uart_tx #(.NB_DATA(8), .SB_TICK(32)) dut32 (
    .i_clk(clk), .i_reset(rst_n), .i_tick(tick), .i_tx_start(start32),
    .i_data(data32), .o_tx(tx32), .o_busy(busy32), .o_tx_done(done32)
  );

  always #5 clk = ~clk;

  // Baud tick: one cycle high every `gap` clocks (continuous when gap is 1).
  initial begin
    int cnt;
    cnt  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      cnt++;
      if (cnt >= gap) begin
        tick = 1'b1;
        cnt  = 0;
      end else begin
        tick = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sb, input logic s, input logic [7:0] d);
    if (sb == 32) begin
      start32 = s;
      data32  = d;
    end else begin
      start16 = s;
      data16  = d;
    end
  endtask

  function automatic logic [2:0] outs(input int sb);
    return (sb == 32) ? {tx32, busy32, done32} : {tx16, busy16, done16};
  endfunction

  // Model: after n ticks since acceptance the line carries frame bit n/16, where bit 0 is
  // the start bit, bits 1..8 are data LSB first and everything after is stop/idle.
  // mode 0: plain frame; mode 1: stray request with 8'hFF mid-data; mode 2: queue `nxt`
  // in the done cycle.
  task automatic tx_frame(input logic [7:0] d, input int sb, input int mode,
                          input logic [7:0] nxt, input bit prestarted);
    int n, total, cyc, idx;
    bit tk;
    logic exp_tx;
    logic [2:0] o;
    logic [7:0] dec;
    total = 16 * 9 + sb;
    dec = 8'h00;
    if (!prestarted) begin
      @(negedge clk);
      set_start(sb, 1'b1, d);
    end
    @(posedge clk); #1;
    set_start(sb, 1'b0, 8'($urandom));
    o = outs(sb);
    chk("accept_tx", o[2], 1'b0);
    chk("accept_busy", o[1], 1'b1);
    chk("accept_done", o[0], 1'b0);
    n = 0;
    cyc = 0;
    while (n < total && cyc < 4000) begin
      @(posedge clk);
      tk = tick;
      #1;
      cyc++;
      if (tk) n++;
      idx = n / 16;
      if (idx == 0)      exp_tx = 1'b0;
      else if (idx <= 8) exp_tx = d[idx-1];
      else               exp_tx = 1'b1;
      o = outs(sb);
      chk("line", o[2], exp_tx);
      chk("busy", o[1], n < total);
      chk("done", o[0], (n == total) && tk);
      if (tk && (n % 16) == 8 && idx >= 1 && idx <= 8) dec[idx-1] = o[2];
      if (mode == 1) begin
        if (tk && n == 50) set_start(sb, 1'b1, 8'hFF);
        else               set_start(sb, 1'b0, 8'hFF);
      end
      if (mode == 2 && n == total) set_start(sb, 1'b1, nxt);
    end
    chk("tick_count", n, total);
    chk("decoded", dec, d);
    if (mode != 2) begin
      @(posedge clk); #1;
      o = outs(sb);
      chk("after_tx", o[2], 1'b1);
      chk("after_busy", o[1], 1'b0);
      chk("after_done", o[0], 1'b0);
    end
  endtask

  initial begin
    int n, cyc;
    bit tk;
    logic [7:0] d;
    int sb;

    rst_n   = 1'b0;
    start16 = 1'b0;
    start32 = 1'b0;
    data16  = 8'h00;
    data32  = 8'h00;

    // Reset held with requests toggling: line stays idle on both instances.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start16 = i[0];
      start32 = ~i[0];
      data16  = 8'($urandom);
      data32  = 8'($urandom);
      @(posedge clk); #1;
      chk("rst_tx", tx16, 1'b1);
      chk("rst_busy", busy16, 1'b0);
      chk("rst_done", done16, 1'b0);
      chk("rst_tx32", tx32, 1'b1);
      chk("rst_busy32", busy32, 1'b0);
      chk("rst_done32", done32, 1'b0);
    end
    @(negedge clk);
    start16 = 1'b0;
    start32 = 1'b0;
    rst_n   = 1'b1;
    repeat (3) @(negedge clk);

    gap = 4;
    tx_frame(8'hA5, 16, 0, 8'h00, 1'b0);
    tx_frame(8'h3C, 16, 1, 8'h00, 1'b0);
    tx_frame(8'h80, 16, 2, 8'h01, 1'b0);
    tx_frame(8'h01, 16, 0, 8'h00, 1'b1);

    // Reset pulse during data bit 3 of 8'h55.
    @(negedge clk);
    set_start(16, 1'b1, 8'h55);
    @(posedge clk); #1;
    set_start(16, 1'b0, 8'h00);
    n = 0;
    cyc = 0;
    while (n < 16 * 4 + 4 && cyc < 2000) begin
      @(posedge clk);
      tk = tick;
      #1;
      cyc++;
      if (tk) n++;
    end
    chk("midrst_reach", n, 16 * 4 + 4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_tx", tx16, 1'b1);
    chk("midrst_busy", busy16, 1'b0);
    chk("midrst_done", done16, 1'b0);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      chk("postrst_tx", tx16, 1'b1);
      chk("postrst_busy", busy16, 1'b0);
      chk("postrst_done", done16, 1'b0);
    end
    tx_frame(8'hC3, 16, 0, 8'h00, 1'b0);

    // Two stop bits.
    tx_frame(8'h00, 32, 0, 8'h00, 1'b0);

    // Random words, tick spacing and stop length.
    for (int i = 0; i < 8; i++) begin
      gap = int'($urandom_range(1, 6));
      d   = 8'($urandom);
      sb  = ($urandom_range(0, 1) == 0) ? 16 : 32;
      tx_frame(d, sb, 0, 8'h00, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
